// File: rtl/huffman_decoder.sv
// Serial-bit Huffman decoder for the 6-symbol gray alphabet, table-driven (HC/M pairs).
// Optional HUFFDEC_ERR_CHECK_EN: sticky err flag on an 8-bit prefix matching no code.
module huffman_decoder #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tbl_load,
  input  logic [7:0]       HC1,
  input  logic [7:0]       HC2,
  input  logic [7:0]       HC3,
  input  logic [7:0]       HC4,
  input  logic [7:0]       HC5,
  input  logic [7:0]       HC6,
  input  logic [7:0]       M1,
  input  logic [7:0]       M2,
  input  logic [7:0]       M3,
  input  logic [7:0]       M4,
  input  logic [7:0]       M5,
  input  logic [7:0]       M6,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic             bit_ready,
  output logic             sym_valid,
  output logic [7:0]       sym_data,
  input  logic             sym_ready,
  output logic [CNT_W-1:0] sym_cnt,
  output logic             err
);

  localparam logic [0:0] NO_TBL = 1'b0;
  localparam logic [0:0] RUN    = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [7:0]       hc_q [6];
  logic [7:0]       m_q  [6];
  logic [7:0]       hc_in [6];
  logic [7:0]       m_in  [6];
  logic [7:0]       acc_q, acc_d;
  logic [3:0]       len_q, len_d;
  logic             sym_valid_q, sym_valid_d;
  logic [7:0]       sym_data_q, sym_data_d;
  logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;

  logic       accept;
  logic [7:0] acc_shift;
  logic [3:0] len_inc;
  logic [7:0] len_mask;
  logic       hit;
  logic [7:0] hit_sym;
  logic       overlong;

  assign hc_in[0] = HC1;
  assign hc_in[1] = HC2;
  assign hc_in[2] = HC3;
  assign hc_in[3] = HC4;
  assign hc_in[4] = HC5;
  assign hc_in[5] = HC6;
  assign m_in[0]  = M1;
  assign m_in[1]  = M2;
  assign m_in[2]  = M3;
  assign m_in[3]  = M4;
  assign m_in[4]  = M5;
  assign m_in[5]  = M6;

  // Ready drops only while an unconsumed symbol sits in the output register.
  assign bit_ready = (state_q == RUN) && !(sym_valid_q && !sym_ready);
  assign sym_valid = sym_valid_q;
  assign sym_data  = sym_data_q;
  assign sym_cnt   = sym_cnt_q;

  always_comb begin
    accept    = bit_valid && bit_ready && !tbl_load;
    acc_shift = {acc_q[6:0], bit_in};
    len_inc   = len_q + 4'd1;
    len_mask  = (len_inc >= 4'd8) ? 8'hFF : ((8'd1 << len_inc) - 8'd1);
    hit       = 1'b0;
    hit_sym   = '0;
    // Ascending scan with first-hit latch gives lowest-index priority.
    for (int unsigned i = 0; i < 6; i++) begin
      if (!hit && (m_q[i] != '0) && (m_q[i] == len_mask) &&
          ((acc_shift & m_q[i]) == (hc_q[i] & m_q[i]))) begin
        hit     = 1'b1;
        hit_sym = 8'(i + 1);
      end
    end
    overlong = (len_inc == 4'd8) && !hit;
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    len_d       = len_q;
    sym_valid_d = sym_valid_q;
    sym_data_d  = sym_data_q;
    sym_cnt_d   = sym_cnt_q;
    if (tbl_load) begin
      state_d     = RUN;
      acc_d       = '0;
      len_d       = '0;
      sym_valid_d = 1'b0;
      sym_cnt_d   = '0;
    end else begin
      if (sym_valid_q && sym_ready) begin
        sym_valid_d = 1'b0;
      end
      if (accept) begin
        if (hit) begin
          sym_valid_d = 1'b1;
          sym_data_d  = hit_sym;
          acc_d       = '0;
          len_d       = '0;
          sym_cnt_d   = sym_cnt_q + CNT_W'(1);
        end else if (overlong) begin
          acc_d = '0;
          len_d = '0;
        end else begin
          acc_d = acc_shift;
          len_d = len_inc;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= NO_TBL;
      acc_q       <= '0;
      len_q       <= '0;
      sym_valid_q <= 1'b0;
      sym_data_q  <= '0;
      sym_cnt_q   <= '0;
      for (int unsigned i = 0; i < 6; i++) begin
        hc_q[i] <= '0;
        m_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      len_q       <= len_d;
      sym_valid_q <= sym_valid_d;
      sym_data_q  <= sym_data_d;
      sym_cnt_q   <= sym_cnt_d;
      if (tbl_load) begin
        for (int unsigned i = 0; i < 6; i++) begin
          hc_q[i] <= hc_in[i];
          m_q[i]  <= m_in[i];
        end
      end
    end
  end

`ifdef HUFFDEC_ERR_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (tbl_load) begin
      err_d = 1'b0;
    end else if (accept && overlong) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_huffman_decoder.sv
// Self-checking bench for huffman_decoder: codebook-level model compared every cycle,
// plus directed literal expectations for the documented scenarios.
module tb_huffman_decoder;

`ifdef HUFFDEC_ERR_CHECK_EN
  localparam int ERR_EN = 1;
`else
  localparam int ERR_EN = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tbl_load;
  logic [7:0]  tb_hc [6];
  logic [7:0]  tb_m  [6];
  logic        bit_valid;
  logic        bit_in;
  logic        bit_ready;
  logic        sym_valid;
  logic [7:0]  sym_data;
  logic        sym_ready;
  logic [15:0] sym_cnt;
  logic        err;

  int checks = 0;
  int errors = 0;

  huffman_decoder #(.CNT_W(16)) dut (
    .clk(clk), .reset(rst_n), .tbl_load(tbl_load),
    .HC1(tb_hc[0]), .HC2(tb_hc[1]), .HC3(tb_hc[2]),
    .HC4(tb_hc[3]), .HC5(tb_hc[4]), .HC6(tb_hc[5]),
    .M1(tb_m[0]), .M2(tb_m[1]), .M3(tb_m[2]),
    .M4(tb_m[3]), .M5(tb_m[4]), .M6(tb_m[5]),
    .bit_valid(bit_valid), .bit_in(bit_in), .bit_ready(bit_ready),
    .sym_valid(sym_valid), .sym_data(sym_data), .sym_ready(sym_ready),
    .sym_cnt(sym_cnt), .err(err)
  );

  always #5 clk = ~clk;

  // Model state: the loaded codebook, pending prefix bits and the output slot.
  logic [7:0]  m_hc [6];
  logic [7:0]  m_m  [6];
  bit          m_run;
  int          m_bits;
  int          m_nbits;
  bit          m_valid;
  int          m_data;
  logic [15:0] m_cnt;
  bit          m_err;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lookup(input int v, input int n);
    for (int i = 0; i < 6; i++) begin
      int len = 0;
      while (len < 8 && m_m[i][len]) len++;
      if (len > 0 && int'(m_m[i]) == (1 << len) - 1 && len == n &&
          (v % (1 << len)) == (int'(m_hc[i]) % (1 << len)))
        return i + 1;
    end
    return 0;
  endfunction

  task automatic mreset();
    for (int i = 0; i < 6; i++) begin
      m_hc[i] = 8'd0;
      m_m[i]  = 8'd0;
    end
    m_run = 0; m_bits = 0; m_nbits = 0;
    m_valid = 0; m_data = 0; m_cnt = 16'd0; m_err = 0;
  endtask

  task automatic mstep();
    bit rdy;
    int s;
    rdy = m_run && !(m_valid && !sym_ready);
    if (tbl_load) begin
      for (int i = 0; i < 6; i++) begin
        m_hc[i] = tb_hc[i];
        m_m[i]  = tb_m[i];
      end
      m_run = 1; m_bits = 0; m_nbits = 0; m_valid = 0; m_cnt = 16'd0; m_err = 0;
    end else begin
      if (m_valid && sym_ready) m_valid = 0;
      if (bit_valid && rdy) begin
        m_bits  = m_bits * 2 + int'(bit_in);
        m_nbits = m_nbits + 1;
        s = lookup(m_bits, m_nbits);
        if (s != 0) begin
          m_valid = 1; m_data = s; m_cnt = m_cnt + 16'd1;
          m_bits = 0; m_nbits = 0;
        end else if (m_nbits == 8) begin
          m_bits = 0; m_nbits = 0;
          if (ERR_EN != 0) m_err = 1;
        end
      end
    end
  endtask

  initial begin
    mreset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) mreset();
      else mstep();
    end
  end

  always @(negedge clk) begin
    chk("bit_ready", int'(bit_ready), int'(m_run && !(m_valid && !sym_ready)));
    chk("sym_valid", int'(sym_valid), int'(m_valid));
    chk("sym_data",  int'(sym_data),  m_data);
    chk("sym_cnt",   int'(sym_cnt),   int'(m_cnt));
    chk("err",       int'(err),       int'(m_err));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic load_table(input logic [7:0] hc [6], input logic [7:0] m [6],
                            input logic with_bit);
    for (int i = 0; i < 6; i++) begin
      tb_hc[i] = hc[i];
      tb_m[i]  = m[i];
    end
    tbl_load  = 1'b1;
    bit_valid = with_bit;
    bit_in    = 1'b1;
    tick(1);
    tbl_load  = 1'b0;
    bit_valid = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    int n = 0;
    bit_valid = 1'b1;
    bit_in    = b;
    forever begin
      @(negedge clk);
      if (bit_ready) break;
      n++;
      if (n > 50) begin
        chk("bit_accept_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #2;
    bit_valid = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(bits[i]);
  endtask

  logic [7:0] basic_hc [6];
  logic [7:0] basic_m  [6];
  logic [7:0] zero_t   [6];

  initial begin
    basic_hc = '{8'd0, 8'd2, 8'd6, 8'd14, 8'd30, 8'd31};
    basic_m  = '{8'd1, 8'd3, 8'd7, 8'd15, 8'd31, 8'd31};
    zero_t   = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    rst_n = 1'b0; tbl_load = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; sym_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tb_hc[i] = 8'd0;
      tb_m[i]  = 8'd0;
    end
    tick(2);
    chk("rst_bit_ready", int'(bit_ready), 0);
    chk("rst_sym_valid", int'(sym_valid), 0);
    chk("rst_sym_data",  int'(sym_data), 0);
    chk("rst_sym_cnt",   int'(sym_cnt), 0);
    chk("rst_err",       int'(err), 0);
    rst_n = 1'b1;
    bit_valid = 1'b1; bit_in = 1'b0;
    tick(3);
    chk("no_tbl_ready", int'(bit_ready), 0);
    bit_valid = 1'b0;

    // Basic decode; the load cycle also presents a bit that must be ignored.
    load_table(basic_hc, basic_m, 1'b1);
    chk("ready_after_load", int'(bit_ready), 1);
    send_bits(8'b0, 1);
    chk("basic1_valid", int'(sym_valid), 1);
    chk("basic1_data", int'(sym_data), 1);
    send_bits(8'b10, 2);
    chk("basic2_data", int'(sym_data), 2);
    send_bits(8'b110, 3);
    chk("basic3_data", int'(sym_data), 3);
    tick(1);
    chk("basic_pulse_end", int'(sym_valid), 0);
    chk("basic_cnt", int'(sym_cnt), 3);

    // Long codes, then back-to-back single-bit codes.
    load_table(basic_hc, basic_m, 1'b0);
    send_bits(8'b11110, 5);
    chk("long5_data", int'(sym_data), 5);
    send_bits(8'b11111, 5);
    chk("long6_data", int'(sym_data), 6);
    chk("long_cnt", int'(sym_cnt), 2);
    send_bits(8'b00, 2);
    chk("b2b_valid", int'(sym_valid), 1);
    chk("b2b_cnt", int'(sym_cnt), 4);
    tick(1);

    // Backpressure.
    sym_ready = 1'b0;
    send_bits(8'b0, 1);
    bit_valid = 1'b1; bit_in = 1'b1;
    tick(3);
    chk("bp_ready_low", int'(bit_ready), 0);
    chk("bp_data_hold", int'(sym_data), 1);
    chk("bp_valid_hold", int'(sym_valid), 1);
    sym_ready = 1'b1;
    send_bit(1'b1);
    chk("bp_ready_back", int'(bit_ready), 1);
    send_bit(1'b0);
    chk("bp_next_data", int'(sym_data), 2);
    tick(1);

    // Overlong code against an empty table.
    load_table(zero_t, zero_t, 1'b0);
    send_bits(8'hFF, 8);
    chk("ovl_err", int'(err), ERR_EN);
    chk("ovl_no_valid", int'(sym_valid), 0);
    chk("ovl_cnt", int'(sym_cnt), 0);
    load_table(basic_hc, basic_m, 1'b0);
    chk("ovl_err_cleared", int'(err), 0);

    // Reload discards a partial codeword.
    send_bits(8'b11, 2);
    load_table(basic_hc, basic_m, 1'b0);
    send_bits(8'b0, 1);
    chk("reload_data", int'(sym_data), 1);
    chk("reload_cnt", int'(sym_cnt), 1);
    tick(1);

    // Asynchronous reset while a symbol is held.
    sym_ready = 1'b0;
    send_bits(8'b10, 2);
    chk("pre_rst_valid", int'(sym_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_sym_valid", int'(sym_valid), 0);
    chk("arst_sym_data", int'(sym_data), 0);
    chk("arst_sym_cnt", int'(sym_cnt), 0);
    chk("arst_bit_ready", int'(bit_ready), 0);
    chk("arst_err", int'(err), 0);
    sym_ready = 1'b1;
    tick(1);
    rst_n = 1'b1;
    bit_valid = 1'b1; bit_in = 1'b0;
    tick(3);
    chk("arst_needs_load", int'(bit_ready), 0);
    chk("arst_no_decode", int'(sym_cnt), 0);
    bit_valid = 1'b0;
    load_table(basic_hc, basic_m, 1'b0);
    send_bits(8'b1110, 4);
    chk("post_rst_data", int'(sym_data), 4);
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/huffman_decoder.md
# huffman_decoder

Serial-bit Huffman decoder for the 6-symbol gray-level alphabet (values 1..6) produced by the `huffman` encoder block. A code table of six right-aligned codewords with matching masks (the `HC1..HC6` / `M1..M6` format the encoder emits on `code_valid`) is loaded once. A bitstream, MSB of each codeword first, is then accepted one bit per cycle under a valid/ready handshake, and each recognised symbol is emitted through a one-entry output register with its own valid/ready handshake.

## Interface
Parameters:
- `CNT_W`, 16, width of decoded-symbol counter

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `tbl_load`  in  1  one-cycle pulse; latch table inputs
- `HC1..HC6`  in  8 each  codeword i, right-aligned
- `M1..M6`  in  8 each  mask i; the code length is the number of contiguous low ones
- `bit_valid`  in  1  `bit_in` carries a stream bit
- `bit_in`  in  1  stream bit
- `bit_ready`  out  1  decoder accepts a bit this cycle
- `sym_valid`  out  1  `sym_data` holds a decoded symbol
- `sym_data`  out  8  decoded gray value, 1..6
- `sym_ready`  in  1  downstream consumes the symbol
- `sym_cnt`  out  CNT_W  number of symbols emitted since table load
- `err`  out  1  sticky overlong-code flag

## Operation
- **State machine: `NO_TBL`.** Entered on reset. Holds `bit_ready`=0.
  - `tbl_load` → `RUN`.
- **State machine: `RUN`.** Decoding.
  - `tbl_load` re-enters `RUN` with a fresh table.
- **Table load.**
  - Register all 12 table inputs.
  - Clear the accumulator `acc`[7:0], the length counter `len`[3:0], `sym_valid`, `sym_cnt` and `err`.
  - A partial codeword is discarded.
- **Bit acceptance.**
  - A bit is accepted when `bit_valid && bit_ready`.
  - On acceptance: `acc` ← {`acc`[6:0], `bit_in`} and `len` ← `len`+1.
- **Match.** Evaluated on the updated `acc`/`len`.
  - Entry i matches when `M_i` = (1<<`len`)−1 and (`acc` & `M_i`) = (`HC_i` & `M_i`).
  - `M_i`=0 never matches.
  - If several entries match, the lowest i wins.
- **On match.**
  - `sym_data` ← i and `sym_valid` ← 1.
  - `acc` ← 0 and `len` ← 0.
  - `sym_cnt` ← `sym_cnt`+1, wrapping at 2^CNT_W.
- **Ready.** `bit_ready` = (state==`RUN`) && !(`sym_valid` && !`sym_ready`).
  - The output register is never overwritten.
- **Output handshake.** `sym_valid` clears on `sym_valid && sym_ready` unless a new match loads it in the same cycle.
- **Overlong code.** `len` reaching 8 with no match is handled per the Configuration section.

## Timing
- **Reset values.**
  - `bit_ready`=0, `sym_valid`=0, `sym_data`=0, `sym_cnt`=0, `err`=0.
  - State `NO_TBL`; `acc`, `len` and the table registers are 0.
- **Table latency.** `bit_ready` may assert the cycle after the `tbl_load` cycle. Bits presented in the `tbl_load` cycle are not accepted.
- **Symbol latency.** `sym_valid` rises in the cycle after the clock edge that accepts the last bit of a codeword; latency is 1 cycle.
- **Throughput.** One bit per cycle, provided `sym_ready` is high whenever `sym_valid` is.
- **Simultaneous events.**
  - Symbol consumption and acceptance of the last bit of the next codeword in the same cycle: `sym_valid` stays 1 and `sym_data` updates.
  - `tbl_load` together with `bit_valid`: the load wins and the bit is not accepted.
- **Reset mid-stream.** All state returns to reset values immediately. A table load is required before any further bit is accepted.

## Configuration
- **`HUFFDEC_ERR_CHECK_EN` defined.**
  - `len`=8 with no match sets `err`=1, sticky until reset or `tbl_load`.
  - `acc` and `len` clear.
  - No symbol is emitted.
- **Not defined.**
  - `err` is tied to 0.
  - `acc` and `len` silently clear at `len`=8 with no match.
  - No symbol is emitted.

## Test plan
- **Basic decode.**
  - Load HC1..HC6 = 0, 2, 6, 14, 30, 31; M1..M6 = 1, 3, 7, 15, 31, 31.
  - Stream bits 0 / 1 0 / 1 1 0 with `sym_ready`=1 → `sym_data` 1, 2, 3.
  - Each `sym_valid` is a single-cycle pulse 1 cycle after the last bit; `sym_cnt`=3.
- **Long codes.** Same table, stream 1 1 1 1 0 then 1 1 1 1 1 → `sym_data` 5 then 6; `sym_cnt`=2.
- **Backpressure.**
  - Hold `sym_ready`=0 after the first symbol (1) → `bit_ready`=0 and `sym_data` holds 1.
  - Raise `sym_ready` → `bit_ready` returns the next cycle and the next symbol decodes correctly.
- **Overlong code (`HUFFDEC_ERR_CHECK_EN` defined).**
  - Load a table with all `M_i`=0, then stream 8 ones → `err`=1 after the 8th bit, no `sym_valid`.
  - `tbl_load` clears `err`.
- **Reload mid-code.**
  - Stream 1 1 (partial code), pulse `tbl_load` with the basic table, then stream 0 → `sym_data`=1, confirming the partial bits were discarded.
- **Async reset.**
  - Assert `reset`=0 while `sym_valid`=1 → all outputs read 0 before the next clock edge.
  - `bit_ready` stays 0 until a `tbl_load`.
